// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FP32 datapath blocks (adder, divider normaliser).
//   fp32_t   : packed single-precision word {sign, exp[7:0], frac[22:0]}
//   EXP_MAX  : all-ones biased exponent (infinity / NaN)
//   FRAC_W   : stored fraction width
//   MANT_W   : mantissa width including the hidden one
//   packFp() : builds an fp32_t from its three fields
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam int          FRAC_W  = 23;
    localparam int          MANT_W  = 24;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    typedef struct packed {
        logic              sign;
        logic [7:0]        exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Small helper so callers never get the field order wrong
    function automatic fp32_t packFp(input logic s, input logic [7:0] e,
                                     input logic [FRAC_W-1:0] f);
        fp32_t v;
        v.sign = s;
        v.exp  = e;
        v.frac = f;
        return v;
    endfunction

endpackage

// File: rtl/lzc24.sv
// ---------------------------------------------------------------------------
// lzc24
// Combinational 24-bit leading-zero counter. Shared with the divider
// normaliser, so it stays free of any adder-specific behaviour.
//   in[23:0]   : value to scan, bit 23 is the most significant
//   count[4:0] : number of leading zeros (24 when the input is all zero)
//   all_zero   : high when every input bit is zero
// ---------------------------------------------------------------------------
module lzc24 (
    input  logic [23:0] in,
    output logic [4:0]  count,
    output logic        all_zero
);

    // Scan from LSB upward so the highest set bit is the last one to write
    // the count; the default covers the all-zero case.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (in[i]) begin
                count = 5'(23 - i);
            end
        end
    end

    assign all_zero = (in == 24'd0);

endmodule

// File: rtl/fp32_add_normalize.sv
// ---------------------------------------------------------------------------
// fp32_add_normalize
// Post-alignment stage of the FP32 adder: adds or subtracts the aligned
// fractions, renormalises with a leading-zero count and left shift, and
// emits a packed FP32 result plus status flags over valid/ready.
//
// Ports
//   clk_i, rst_i             : clock, asynchronous active-high reset
//   in_valid / in_ready      : upstream handshake
//   sign_big, exp_big        : sign and biased exponent of the larger operand
//   big_fract, small_fract   : {.., 1, frac} and the aligned small fraction
//   eff_sub                  : 1 = big - small, 0 = big + small
//   out_valid / out_ready    : downstream handshake
//   result                   : packed FP32 {sign, exp, frac}
//   flag_zero/ovf/unf        : exact zero, overflow to inf, underflow to zero
//
// Configuration macro
//   FPU_ADD_PIPE2_EN : when defined, the add result is registered before the
//                      normaliser (2-cycle latency); otherwise add and
//                      normalise share one combinational path (1 cycle).
// ---------------------------------------------------------------------------
module fp32_add_normalize
    import fpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_big,
    input  logic [7:0]  exp_big,
    input  logic [31:0] big_fract,
    input  logic [31:0] small_fract,
    input  logic        eff_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_zero,
    output logic        flag_ovf,
    output logic        flag_unf
);

    // Front end
    logic [24:0]       w_sum;
    logic              w_bypass;
    logic [24:0]       w_stageSum;
    logic              w_unusedHighBits;

    // Normaliser inputs (registered or direct depending on build)
    logic [24:0]       w_nSum;
    logic              w_nSign;
    logic [7:0]        w_nExp;
    logic              w_nBypass;
    logic              w_upValid;

    // Normaliser internals and outputs
    logic [4:0]        w_lzCount;
    logic              w_lzAllZero;
    logic [7:0]        w_lzExt;
    logic [7:0]        w_expInc;
    logic [FRAC_W-1:0] w_shiftFrac;
    fp32_t             w_nResult;
    logic              w_nZero;
    logic              w_nOvf;
    logic              w_nUnf;

    // Output stage
    logic              w_outStageReady;
    logic              r_outValid;
    fp32_t             r_result;
    logic              r_flagZero;
    logic              r_flagOvf;
    logic              r_flagUnf;

    assign w_unusedHighBits = ^{big_fract[31:25], small_fract[31:25]};

    // Upstream guarantees |big| >= |small|, so the subtraction never wraps.
    // On bypass the sum is meaningless, so the big fraction rides in its
    // place; this lets the optional pipeline register carry only one field.
    always_comb begin
        w_sum      = eff_sub ? (big_fract[24:0] - small_fract[24:0])
                             : (big_fract[24:0] + small_fract[24:0]);
        w_bypass   = (exp_big == 8'h00) || (exp_big == EXP_MAX);
        w_stageSum = w_bypass ? {2'b00, big_fract[FRAC_W-1:0]} : w_sum;
    end

    assign w_outStageReady = !r_outValid || out_ready;

`ifdef FPU_ADD_PIPE2_EN
    logic        r_s1Valid;
    logic [24:0] r_s1Sum;
    logic        r_s1Sign;
    logic [7:0]  r_s1Exp;
    logic        r_s1Bypass;
    logic        w_s1Ready;

    assign w_s1Ready = !r_s1Valid || w_outStageReady;
    assign in_ready  = w_s1Ready;

    // Stage 1 holds the raw add result; data only moves on a transfer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1Valid  <= 1'b0;
            r_s1Sum    <= '0;
            r_s1Sign   <= 1'b0;
            r_s1Exp    <= '0;
            r_s1Bypass <= 1'b0;
        end else begin
            if (w_s1Ready) begin
                r_s1Valid <= in_valid;
            end
            if (in_valid && w_s1Ready) begin
                r_s1Sum    <= w_stageSum;
                r_s1Sign   <= sign_big;
                r_s1Exp    <= exp_big;
                r_s1Bypass <= w_bypass;
            end
        end
    end

    assign w_nSum    = r_s1Sum;
    assign w_nSign   = r_s1Sign;
    assign w_nExp    = r_s1Exp;
    assign w_nBypass = r_s1Bypass;
    assign w_upValid = r_s1Valid;
`else
    assign in_ready  = w_outStageReady;
    assign w_nSum    = w_stageSum;
    assign w_nSign   = sign_big;
    assign w_nExp    = exp_big;
    assign w_nBypass = w_bypass;
    assign w_upValid = in_valid;
`endif

    lzc24 u_lzc (
        .in       (w_nSum[23:0]),
        .count    (w_lzCount),
        .all_zero (w_lzAllZero)
    );

    assign w_lzExt     = {3'b000, w_lzCount};
    assign w_expInc    = 8'(w_nExp + 8'd1);
    assign w_shiftFrac = 23'(w_nSum[23:0] << w_lzCount);

    // Result selection; checks are ordered so exactly one flag can fire.
    // Rounding is plain truncation in both the carry and the shift paths.
    always_comb begin
        w_nResult = packFp(1'b0, 8'h00, '0);
        w_nZero   = 1'b0;
        w_nOvf    = 1'b0;
        w_nUnf    = 1'b0;
        if (w_nBypass) begin
            w_nResult = packFp(w_nSign, w_nExp, w_nSum[FRAC_W-1:0]);
        end else if (!w_nSum[24] && w_lzAllZero) begin
            w_nZero = 1'b1;
        end else if (w_nSum[24]) begin
            if (w_expInc == EXP_MAX) begin
                w_nResult = packFp(w_nSign, EXP_MAX, '0);
                w_nOvf    = 1'b1;
            end else begin
                w_nResult = packFp(w_nSign, w_expInc, w_nSum[23:1]);
            end
        end else if (w_nExp <= w_lzExt) begin
            w_nResult = packFp(w_nSign, 8'h00, '0);
            w_nUnf    = 1'b1;
        end else begin
            w_nResult = packFp(w_nSign, 8'(w_nExp - w_lzExt), w_shiftFrac);
        end
    end

    // Output register: holds steady while the consumer stalls
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_flagZero <= 1'b0;
            r_flagOvf  <= 1'b0;
            r_flagUnf  <= 1'b0;
        end else begin
            if (w_outStageReady) begin
                r_outValid <= w_upValid;
            end
            if (w_upValid && w_outStageReady) begin
                r_result   <= w_nResult;
                r_flagZero <= w_nZero;
                r_flagOvf  <= w_nOvf;
                r_flagUnf  <= w_nUnf;
            end
        end
    end

    assign out_valid = r_outValid;
    assign result    = r_result;
    assign flag_zero = r_flagZero;
    assign flag_ovf  = r_flagOvf;
    assign flag_unf  = r_flagUnf;

endmodule

// File: doc/fp32_add_normalize.md
# fp32_add_normalize

Post-alignment stage of the FP32 adder. Sits directly downstream of the small-fraction right shifter. It takes the exponent-larger ("big") operand's fraction and the already-shifted small fraction, then adds or subtracts them. It renormalises the result with a leading-zero count and left shift, and emits a packed FP32 result with status flags through a valid/ready pipeline.

## Interface
- No parameters. The pipeline depth is selected by macro (see Configuration).
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- sign_big  in  1  sign of big operand, which is also the result sign.
- exp_big  in  8  biased exponent of big operand.
- big_fract  in  32  {8'b0, 1'b1, frac[22:0]}.
- small_fract  in  32  small fraction after alignment shift; all zero when the small operand was forced to zero.
- eff_sub  in  1  1 selects big − small; 0 selects big + small.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the beat.
- result  out  32  packed FP32 {sign, exp[7:0], frac[22:0]}.
- flag_zero / flag_ovf / flag_unf  out  1 each  exact zero, overflow to infinity, and underflow flushed to zero.

## Operation
- Upstream guarantees |big| ≥ |small|, so subtraction never goes negative.
- sum[24:0] = eff_sub ? big_fract[24:0] − small_fract[24:0] : big_fract[24:0] + small_fract[24:0]. Bits 31:25 of the inputs are ignored.
- Bypass: if exp_big is 0 or 255, result = {sign_big, exp_big, big_fract[22:0]} with all flags 0. This passes specials and zeros resolved upstream straight through.
- sum == 0: result = 32'h0000_0000 (+0, regardless of sign_big); flag_zero = 1.
- sum[24] == 1 (carry): frac = sum[23:1], exp = exp_big + 1.
  - If exp == 255: result = {sign_big, 8'hFF, 23'b0}; flag_ovf = 1.
- Otherwise lz = count of leading zeros of sum[23:0], range 0..23.
  - If exp_big ≤ lz: result = {sign_big, 31'b0}; flag_unf = 1. Denormals are not produced.
  - Else exp = exp_big − lz, and frac = (sum[23:0] << lz)[22:0].
- Rounding is truncation. Bits lost in alignment or in the carry shift are discarded.
- Only one flag is ever set per beat.

## Timing
- Each register stage advances when it is empty or its downstream stage accepts. Per stage, ready = !valid_q || ready_downstream.
- in_ready is combinational from out_ready through the stage chain. There is no skid buffer.
- A beat transfers on any edge where valid and ready are both high. Data is captured only on transfer.
- While out_valid = 1 and out_ready = 0, result and flags hold stable.
- Latency from in transfer to out_valid:
  - 1 cycle without FPU_ADD_PIPE2_EN.
  - 2 cycles with FPU_ADD_PIPE2_EN.
- Throughput is 1 beat per cycle when out_ready is held high.
- Reset: all valid bits clear immediately, which drives out_valid = 0. result = 0 and all flags = 0.
  - In-flight beats are dropped.
  - in_ready = 1 while the core is in reset.
  - The first accept occurs on the first edge after rst_i falls.

## Configuration
- FPU_ADD_PIPE2_EN defined:
  - Stage 1 registers {sum[24:0], sign_big, exp_big, bypass}.
  - Stage 2 performs lzc, shift and exponent update, then registers result and flags.
- FPU_ADD_PIPE2_EN undefined: add and normalize form a single combinational path into one output register.
- Function is bit-identical in both builds; only latency differs.

## Structure
- Shared package fpu_pkg holds:
  - fp32_t packed struct {sign, exp[7:0], frac[22:0]}.
  - Constants EXP_MAX = 8'hFF, FRAC_W = 23, MANT_W = 24.
- Sub-module lzc24: combinational 24-bit leading-zero counter.
  - Ports: in[23:0], count[4:0], all_zero.
  - It is instantiated once, and reused by the divider normaliser later.

## Test plan
- Add 1.0 + 1.0: exp_big = 127, big = small = 32'h0080_0000, eff_sub = 0 → result 32'h4000_0000, flags 0.
- Subtract 1.5 − 1.0: exp_big = 127, big = 32'h00C0_0000, small = 32'h0080_0000, eff_sub = 1 → lz = 1, result 32'h3F00_0000.
- Exact cancel: big = small = 32'h0080_0000, eff_sub = 1, sign_big = 1 → result 32'h0000_0000, flag_zero = 1.
- Overflow: exp_big = 254, big = 32'h00FF_FFFF, small = 32'h0000_0001, eff_sub = 0 → result 32'h7F80_0000, flag_ovf = 1.
- Underflow: exp_big = 1, big = 32'h00C0_0000, small = 32'h0080_0000, eff_sub = 1, sign_big = 1 → result 32'h8000_0000, flag_unf = 1.
- Backpressure and reset:
  - Stream 4 beats and hold out_ready = 0 for 3 cycles. The held beat must stay stable, in_ready must go 0, and no beat may be lost or duplicated; then check the latency for the active build.
  - Assert rst_i mid-stream → out_valid drops in the same cycle and no stale beat appears afterwards.
